// File: rtl/sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_gen
// Brief    : Raster-scan 3x3 window generator with two line buffers feeding
//            the Sobel pre-stage; emits interior windows only.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sof_i,
    input  logic       pix_valid_i,
    input  logic [7:0] pix_i,
    output logic       sobel_en,
    output logic [7:0] w_0,
    output logic [7:0] w_1,
    output logic [7:0] w_2,
    output logic [7:0] w_3,
    output logic [7:0] w_4,
    output logic [7:0] w_5,
    output logic [7:0] w_6,
    output logic [7:0] w_7,
    output logic [7:0] w_8,
    output logic       frame_done_o
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_COL_MIN  = CW'(2);
    localparam logic [RW-1:0] C_ROW_MIN  = RW'(2);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    r_lb2 [IMG_W];
    logic [7:0]    r_win [9];
    logic          r_sobel_en;
    logic          r_frame_done;

    logic          w_accept;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [7:0]    w_lb1_rd;
    logic [7:0]    w_lb2_rd;
    logic          w_last;
    logic          w_interior;

    // A start-of-frame pixel overrides the running position with (0,0).
    always_comb begin
        w_accept   = pix_valid_i & ~rst_i;
        w_col      = sof_i ? '0 : r_col;
        w_row      = sof_i ? '0 : r_row;
        w_lb1_rd   = r_lb1[w_col];
        w_lb2_rd   = r_lb2[w_col];
        w_last     = (w_row == C_ROW_LAST) && (w_col == C_COL_LAST);
        w_interior = (w_row >= C_ROW_MIN) && (w_col >= C_COL_MIN);
    end

    // Line buffers carry no reset so they map onto plain RAM; stale rows are
    // masked by the interior gate.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lb2[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= pix_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col        <= '0;
            r_row        <= '0;
            r_sobel_en   <= 1'b0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_sobel_en   <= 1'b0;
            r_frame_done <= 1'b0;
            if (pix_valid_i) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= w_lb2_rd;
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= w_lb1_rd;
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= pix_i;

                r_sobel_en   <= w_interior;
                r_frame_done <= w_last;

                if (w_col == C_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == C_ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
        end
    end

    assign sobel_en     = r_sobel_en;
    assign frame_done_o = r_frame_done;
    assign w_0          = r_win[0];
    assign w_1          = r_win[1];
    assign w_2          = r_win[2];
    assign w_3          = r_win[3];
    assign w_4          = r_win[4];
    assign w_5          = r_win[5];
    assign w_6          = r_win[6];
    assign w_7          = r_win[7];
    assign w_8          = r_win[8];

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_window_gen
// Brief    : Self-checking bench for sobel_window_gen (4x4 and 5x3 geometries)
//            against an image-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_window_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sof = 1'b0;
    logic [1:0] pv  = '0;
    logic [7:0] pix = '0;

    always #5 clk = ~clk;

    logic            en [2];
    logic            fd [2];
    logic [8:0][7:0] wa;
    logic [8:0][7:0] wb;

    sobel_window_gen #(.IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .sof_i(sof), .pix_valid_i(pv[0]), .pix_i(pix),
        .sobel_en(en[0]),
        .w_0(wa[0]), .w_1(wa[1]), .w_2(wa[2]), .w_3(wa[3]), .w_4(wa[4]),
        .w_5(wa[5]), .w_6(wa[6]), .w_7(wa[7]), .w_8(wa[8]),
        .frame_done_o(fd[0])
    );

    sobel_window_gen #(.IMG_W(5), .IMG_H(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .sof_i(sof), .pix_valid_i(pv[1]), .pix_i(pix),
        .sobel_en(en[1]),
        .w_0(wb[0]), .w_1(wb[1]), .w_2(wb[2]), .w_3(wb[3]), .w_4(wb[4]),
        .w_5(wb[5]), .w_6(wb[6]), .w_7(wb[7]), .w_8(wb[8]),
        .frame_done_o(fd[1])
    );

    int n_checks = 0;
    int n_err    = 0;
    bit armed    = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dw(input int k, input int i);
        return (k == 0) ? wa[i] : wb[i];
    endfunction

    function automatic int geo_w(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    function automatic int geo_h(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    // Reference model: the accepted pixels are stored by image position and
    // each interior window is read straight out of the image.
    int         m_row [2];
    int         m_col [2];
    logic [7:0] img   [2][4][5];
    logic [7:0] ew    [2][9];
    bit         ew_full [2];
    bit         e_en  [2];
    bit         e_fd  [2];
    int         mr, mc;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_row[k] = 0;
                m_col[k] = 0;
                for (int i = 0; i < 9; i++) ew[k][i] = 8'h00;
                ew_full[k] = 1'b1;
                e_en[k]    = 1'b0;
                e_fd[k]    = 1'b0;
            end else if (pv[k]) begin
                mr = sof ? 0 : m_row[k];
                mc = sof ? 0 : m_col[k];
                img[k][mr][mc] = pix;
                // Bottom row is always the three most recently accepted pixels.
                ew[k][6] = ew[k][7];
                ew[k][7] = ew[k][8];
                ew[k][8] = pix;
                e_en[k] = (mr >= 2) && (mc >= 2);
                e_fd[k] = (mr == geo_h(k) - 1) && (mc == geo_w(k) - 1);
                if (e_en[k]) begin
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            ew[k][dr*3+dc] = img[k][mr-2+dr][mc-2+dc];
                    ew_full[k] = 1'b1;
                end else begin
                    ew_full[k] = 1'b0;
                end
                if (mc == geo_w(k) - 1) begin
                    m_col[k] = 0;
                    m_row[k] = (mr == geo_h(k) - 1) ? 0 : mr + 1;
                end else begin
                    m_col[k] = mc + 1;
                    m_row[k] = mr;
                end
            end else begin
                e_en[k] = 1'b0;
                e_fd[k] = 1'b0;
            end
        end
    end

    int         cnt_en [2];
    int         cnt_fd [2];
    logic [7:0] first_win [2][9];
    logic [7:0] last_win  [2][9];
    bit         last_fd   [2];
    logic [7:0] centres   [2][8];

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk("sobel_en", k, 32'(en[k]), 32'(e_en[k]));
                chk("frame_done", k, 32'(fd[k]), 32'(e_fd[k]));
                for (int i = 0; i < 9; i++)
                    if (ew_full[k] || i >= 6)
                        chk($sformatf("w_%0d", i), k, 32'(dw(k, i)), 32'(ew[k][i]));
                if (en[k] === 1'b1) begin
                    if (cnt_en[k] < 8) centres[k][cnt_en[k]] = dw(k, 4);
                    cnt_en[k]++;
                    for (int i = 0; i < 9; i++) begin
                        if (cnt_en[k] == 1) first_win[k][i] = dw(k, i);
                        last_win[k][i] = dw(k, i);
                    end
                    last_fd[k] = fd[k];
                end
                if (fd[k] === 1'b1) cnt_fd[k]++;
            end
        end
    end

    logic [7:0] ramp_first [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

    task automatic px(input int k, input bit s, input logic [7:0] p);
        @(negedge clk);
        pv    = '0;
        pv[k] = 1'b1;
        sof   = s;
        pix   = p;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pv  = '0;
            sof = 1'b0;
        end
    endtask

    task automatic frame(input int k, input bit fsof, input bit gap);
        for (int r = 0; r < geo_h(k); r++)
            for (int c = 0; c < geo_w(k); c++) begin
                px(k, fsof && r == 0 && c == 0, 8'(r * 16 + c));
                if (gap) idle(1);
            end
        idle(3);
    endtask

    task automatic clr_stats();
        for (int k = 0; k < 2; k++) begin
            cnt_en[k]  = 0;
            cnt_fd[k]  = 0;
            last_fd[k] = 1'b0;
        end
    endtask

    task automatic chk_ramp_first(input string nm);
        for (int i = 0; i < 9; i++)
            chk(nm, 0, 32'(first_win[0][i]), 32'(ramp_first[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_stats();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset sobel_en", k, 32'(en[k]), 32'd0);
            chk("reset frame_done", k, 32'(fd[k]), 32'd0);
            chk("reset w_4", k, 32'(dw(k, 4)), 32'd0);
            chk("reset w_8", k, 32'(dw(k, 8)), 32'd0);
        end
        idle(10);

        // 4x4 ramp, continuous
        clr_stats();
        frame(0, 1'b1, 1'b0);
        chk("ramp pulses", 0, 32'(cnt_en[0]), 32'd4);
        chk("ramp frame_done count", 0, 32'(cnt_fd[0]), 32'd1);
        chk_ramp_first("ramp first window");
        chk("ramp last centre", 0, 32'(last_win[0][4]), 32'h22);
        chk("ramp last w_8", 0, 32'(last_win[0][8]), 32'h33);
        chk("ramp last frame_done", 0, 32'(last_fd[0]), 32'd1);

        // same image with 1/0 valid toggling
        clr_stats();
        frame(0, 1'b1, 1'b1);
        chk("gap pulses", 0, 32'(cnt_en[0]), 32'd4);
        chk("gap frame_done count", 0, 32'(cnt_fd[0]), 32'd1);
        chk_ramp_first("gap first window");
        chk("gap last centre", 0, 32'(last_win[0][4]), 32'h22);

        // row wrap on 5x3
        clr_stats();
        frame(1, 1'b1, 1'b0);
        chk("wrap pulses", 1, 32'(cnt_en[1]), 32'd3);
        chk("wrap centre 0", 1, 32'(centres[1][0]), 32'h11);
        chk("wrap centre 1", 1, 32'(centres[1][1]), 32'h12);
        chk("wrap centre 2", 1, 32'(centres[1][2]), 32'h13);
        chk("wrap frame_done count", 1, 32'(cnt_fd[1]), 32'd1);

        // frame aborted by sof at (1,2), then a full frame
        clr_stats();
        px(0, 1'b1, 8'h00);
        for (int c = 1; c < 4; c++) px(0, 1'b0, 8'(c));
        px(0, 1'b0, 8'h10);
        px(0, 1'b0, 8'h11);
        frame(0, 1'b1, 1'b0);
        chk("abort pulses", 0, 32'(cnt_en[0]), 32'd4);
        chk("abort frame_done count", 0, 32'(cnt_fd[0]), 32'd1);
        chk_ramp_first("abort first window");

        // reset after (2,3) with a pixel presented in the reset cycle
        px(0, 1'b1, 8'h00);
        for (int i = 1; i < 12; i++) px(0, 1'b0, 8'((i / 4) * 16 + (i % 4)));
        @(negedge clk);
        rst   = 1'b1;
        pv    = 2'b01;
        sof   = 1'b0;
        pix   = 8'h30;
        @(negedge clk);
        rst = 1'b0;
        pv  = '0;
        chk("post-reset sobel_en", 0, 32'(en[0]), 32'd0);
        chk("post-reset w_4", 0, 32'(dw(0, 4)), 32'd0);
        chk("post-reset w_8", 0, 32'(dw(0, 8)), 32'd0);
        clr_stats();
        frame(0, 1'b0, 1'b0);
        chk("post-reset pulses", 0, 32'(cnt_en[0]), 32'd4);
        chk("post-reset frame_done count", 0, 32'(cnt_fd[0]), 32'd1);
        chk_ramp_first("post-reset first window");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
